// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding and line levels
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } uart_state_t;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_tx_block_if.sv
// uart_tx_block_if: frame request and serial line signals of the UART transmitter
interface uart_tx_block_if #(
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_CNT_BITS  = 14
);
  logic                     tx_start;
  logic [NUM_DATA_BITS-1:0] tx_data;
  logic [NUM_CNT_BITS-1:0]  bit_period;
  logic                     serial_out;
  logic                     tx_busy;
  logic                     tx_done;
  modport master (output tx_start, tx_data, bit_period, input serial_out, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, bit_period, output serial_out, tx_busy, tx_done);
endinterface

// File: rtl/flex_counter.sv
// flex_counter: up-counter wrapping to 1 after rollover_val, with sync clear and registered rollover flag
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count, next_count;
  always_comb
    next_count = clear ? '0 :
                 !count_enable ? count :
                 (count == rollover_val) ? NUM_CNT_BITS'(1) : count + 1'b1;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count         <= next_count;
      rollover_flag <= !clear && (next_count == rollover_val);
    end
  end
endmodule

// File: rtl/uart_tx_block.sv
// uart_tx_block: UART frame transmitter (start bit, LSB-first payload, one stop bit)
// with a per-frame bit period captured when the request is accepted.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_CNT_BITS  = 14
) (
  input  logic             clk,
  input  logic             n_rst,
  uart_tx_block_if.slave   bus
);
  localparam int IDX_W = (NUM_DATA_BITS > 2) ? $clog2(NUM_DATA_BITS) : 1;
  uart_state_t              state;
  logic [NUM_DATA_BITS-1:0] data_sr;
  logic [NUM_CNT_BITS-1:0]  period_reg;
  logic                     accept, bit_done, last_bit;
  assign accept = (state == IDLE) && bus.tx_start;
  // rollover at period-1 so the flag is visible in the final cycle of each bit
  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept || bit_done),
    .count_enable (state != IDLE),
    .rollover_val (period_reg - 1'b1),
    .rollover_flag(bit_done)
  );
  flex_counter #(.NUM_CNT_BITS(IDX_W)) u_index (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept),
    .count_enable (bit_done && (state == DATA_BIT)),
    .rollover_val (IDX_W'(NUM_DATA_BITS - 1)),
    .rollover_flag(last_bit)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      data_sr        <= '0;
      period_reg     <= '0;
      bus.serial_out <= UART_IDLE_LEVEL;
      bus.tx_busy    <= 1'b0;
      bus.tx_done    <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: if (bus.tx_start) begin
          state          <= START_BIT;
          data_sr        <= bus.tx_data;
          period_reg     <= (bus.bit_period < NUM_CNT_BITS'(2)) ? NUM_CNT_BITS'(2) : bus.bit_period;
          bus.serial_out <= UART_START_LEVEL;
          bus.tx_busy    <= 1'b1;
        end
        START_BIT: if (bit_done) begin
          state          <= DATA_BIT;
          bus.serial_out <= data_sr[0];
        end
        DATA_BIT: if (bit_done) begin
          if (last_bit) begin
            state          <= STOP_BIT;
            bus.serial_out <= UART_IDLE_LEVEL;
          end else begin
            data_sr        <= data_sr >> 1;
            bus.serial_out <= data_sr[1];
          end
        end
        STOP_BIT: if (bit_done) begin
          state       <= IDLE;
          bus.tx_busy <= 1'b0;
          bus.tx_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
